// File: rtl/nn_ctrl_pkg.sv
// ============================================================================
// Module : nn_ctrl_pkg
// Brief  : Shared sequencer state encoding and default widths.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_ctrl_pkg;

  localparam int c_def_a_width  = 4;
  localparam int c_def_layer_w  = 4;
  localparam int c_def_to_width = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/layer_cfg_table.sv
// ============================================================================
// Module : layer_cfg_table
// Brief  : Per-layer {p_index, need_act} table, sync write / comb read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_cfg_table #(
  parameter int A_WIDTH = 4,
  parameter int LAYER_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [LAYER_W-1:0] wr_addr,
  input  logic [A_WIDTH-1:0] wr_p_index,
  input  logic               wr_need_act,
  input  logic [LAYER_W-1:0] rd_addr,
  output logic [A_WIDTH-1:0] rd_p_index,
  output logic               rd_need_act
);

  localparam int c_depth = 2 ** LAYER_W;

  logic [A_WIDTH-1:0] r_p_mem   [c_depth];
  logic               r_act_mem [c_depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_depth; i++) begin
        r_p_mem[i]   <= '0;
        r_act_mem[i] <= 1'b0;
      end
    end else if (we) begin
      r_p_mem[wr_addr]   <= wr_p_index;
      r_act_mem[wr_addr] <= wr_need_act;
    end
  end

  assign rd_p_index  = r_p_mem[rd_addr];
  assign rd_need_act = r_act_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
// Module : layer_sequencer
// Brief  : Steps a network through its layers, launching the distributor
//          once per layer with a per-layer timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int A_WIDTH  = c_def_a_width,
  parameter int LAYER_W  = c_def_layer_w,
  parameter int TO_WIDTH = c_def_to_width
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [LAYER_W:0]    num_layers,
  input  logic [TO_WIDTH-1:0] timeout_limit,
  input  logic                cfg_we,
  input  logic [LAYER_W-1:0]  cfg_addr,
  input  logic [A_WIDTH-1:0]  cfg_p_index,
  input  logic                cfg_need_act,
  input  logic                dist_all_done,
  output logic                dist_en,
  output logic [LAYER_W-1:0]  layer_index,
  output logic [A_WIDTH-1:0]  p_index_in,
  output logic                need_act,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LAYER_W:0]    layers_done
);

  state_t              r_state;
  logic [LAYER_W:0]    r_num_layers;
  logic [TO_WIDTH-1:0] r_to_cnt;

  logic [A_WIDTH-1:0]  w_rd_p_index;
  logic                w_rd_need_act;
  logic [TO_WIDTH:0]   w_cnt_inc;
  logic                w_expired;
  logic [LAYER_W:0]    w_done_next;

  // The table is only writable while idle; this includes the start cycle.
  layer_cfg_table #(
    .A_WIDTH (A_WIDTH),
    .LAYER_W (LAYER_W)
  ) u_cfg_table (
    .clk         (clk),
    .rst         (rst),
    .we          (cfg_we & ~busy),
    .wr_addr     (cfg_addr),
    .wr_p_index  (cfg_p_index),
    .wr_need_act (cfg_need_act),
    .rd_addr     (layer_index),
    .rd_p_index  (w_rd_p_index),
    .rd_need_act (w_rd_need_act)
  );

  assign w_cnt_inc   = {1'b0, r_to_cnt} + (TO_WIDTH + 1)'(1);
  assign w_expired   = (timeout_limit != '0) && (w_cnt_inc >= {1'b0, timeout_limit});
  assign w_done_next = layers_done + (LAYER_W + 1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_num_layers <= '0;
      r_to_cnt     <= '0;
      dist_en      <= 1'b0;
      layer_index  <= '0;
      p_index_in   <= '0;
      need_act     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      layers_done  <= '0;
    end else begin
      dist_en <= 1'b0;
      done    <= 1'b0;
      if (r_state != S_IDLE && abort) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              error        <= 1'b0;
              layers_done  <= '0;
              layer_index  <= '0;
              r_num_layers <= num_layers;
              busy         <= 1'b1;
              if (num_layers == '0) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end else begin
                r_state <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            p_index_in <= w_rd_p_index;
            need_act   <= w_rd_need_act;
            dist_en    <= 1'b1;
            r_state    <= S_LAUNCH;
          end
          S_LAUNCH: begin
            r_to_cnt <= '0;
            r_state  <= S_RUN;
          end
          S_RUN: begin
            if (!(&r_to_cnt)) begin
              r_to_cnt <= w_cnt_inc[TO_WIDTH-1:0];
            end
            // Completion wins over a timeout expiring in the same cycle.
            if (dist_all_done) begin
              r_state <= S_NEXT;
            end else if (w_expired) begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end
          end
          S_NEXT: begin
            layers_done <= w_done_next;
            if (w_done_next == r_num_layers) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              layer_index <= layer_index + LAYER_W'(1);
              r_state     <= S_LOAD;
            end
          end
          S_DONE, S_ERR: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// ============================================================================
// Module : tb_layer_sequencer
// Brief  : Randomized scoreboard bench for layer_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_sequencer;

  localparam int A_W = 4;
  localparam int L_W = 4;
  localparam int T_W = 16;

  localparam int EV_LAUNCH = 0;
  localparam int EV_DONE   = 1;
  localparam int EV_ERR    = 2;

  typedef struct {
    int kind;
    int cyc;
    int layer;
    int p;
    int act;
    int ld;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic [L_W:0]   num_layers;
  logic [T_W-1:0] timeout_limit;
  logic           cfg_we;
  logic [L_W-1:0] cfg_addr;
  logic [A_W-1:0] cfg_p_index;
  logic           cfg_need_act;
  logic           dist_all_done;
  logic           dist_en;
  logic [L_W-1:0] layer_index;
  logic [A_W-1:0] p_index_in;
  logic           need_act;
  logic           busy;
  logic           done;
  logic           error;
  logic [L_W:0]   layers_done;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  tbl_p [16];
  int  tbl_a [16];
  ev_t exp_q [$];
  logic prev_err = 1'b0;

  layer_sequencer #(
    .A_WIDTH  (A_W),
    .LAYER_W  (L_W),
    .TO_WIDTH (T_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .num_layers    (num_layers),
    .timeout_limit (timeout_limit),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_p_index   (cfg_p_index),
    .cfg_need_act  (cfg_need_act),
    .dist_all_done (dist_all_done),
    .dist_en       (dist_en),
    .layer_index   (layer_index),
    .p_index_in    (p_index_in),
    .need_act      (need_act),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .layers_done   (layers_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int layer,
                         input int p, input int act, input int ld);
    ev_t e;
    e.kind = kind; e.cyc = c; e.layer = layer; e.p = p; e.act = act; e.ld = ld;
    exp_q.push_back(e);
  endtask

  // Monitor: every launch, done pulse or error rise must match the next expectation.
  always @(negedge clk) begin
    ev_t e;
    int  k;
    if (dist_en || done || (error && !prev_err)) begin
      k = dist_en ? EV_LAUNCH : (done ? EV_DONE : EV_ERR);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (e.kind == EV_LAUNCH) begin
          check("launch_layer", int'(layer_index), e.layer);
          check("launch_p_index", int'(p_index_in), e.p);
          check("launch_need_act", int'(need_act), e.act);
          check("launch_busy", int'(busy), 1);
        end else if (e.kind == EV_DONE) begin
          check("done_layers_done", int'(layers_done), e.ld);
        end
      end
    end
    prev_err <= error;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int p, input int act);
    cfg_we       = 1'b1;
    cfg_addr     = L_W'(a);
    cfg_p_index  = A_W'(p);
    cfg_need_act = 1'(act);
    step();
    cfg_we = 1'b0;
    tbl_p[a] = p % 16;
    tbl_a[a] = act % 2;
  endtask

  // Reference: a layer finishing d cycles after its launch succeeds unless
  // d exceeds a nonzero timeout; next launch 3 cycles later, done 2 later.
  task automatic run_case(input int n, input int tlim, input int dly[16],
                          input bit noise, input bit wos);
    int s, li, r, endc;
    bit stop, err_exp;
    int ad_q[$];
    int la_q[$];
    s = cyc;
    start         = 1'b1;
    num_layers    = (L_W + 1)'(n);
    timeout_limit = T_W'(tlim);
    if (wos) begin
      cfg_we       = 1'b1;
      cfg_addr     = '0;
      cfg_p_index  = A_W'($urandom);
      cfg_need_act = 1'($urandom);
      tbl_p[0] = int'(cfg_p_index);
      tbl_a[0] = int'(cfg_need_act);
    end
    err_exp = 1'b0;
    endc = s + 2;
    if (n == 0) begin
      push_ev(EV_DONE, s + 1, 0, 0, 0, 0);
    end else begin
      li = s + 2;
      stop = 1'b0;
      for (int i = 0; i < n && !stop; i++) begin
        push_ev(EV_LAUNCH, li, i, tbl_p[i], tbl_a[i], 0);
        la_q.push_back(li);
        if (tlim != 0 && dly[i] > tlim) begin
          push_ev(EV_ERR, li + tlim + 1, 0, 0, 0, 0);
          endc = li + tlim + 2;
          stop = 1'b1;
          err_exp = 1'b1;
        end else begin
          r = li + dly[i];
          ad_q.push_back(r);
          if (i == n - 1) begin
            push_ev(EV_DONE, r + 2, 0, 0, 0, n);
            endc = r + 3;
          end else begin
            li = r + 3;
          end
        end
      end
    end
    step();
    start  = 1'b0;
    cfg_we = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("error_cleared_by_start", int'(error), 0);
    while (cyc < endc) begin
      dist_all_done = 1'b0;
      foreach (ad_q[j]) if (ad_q[j] == cyc) dist_all_done = 1'b1;
      if (noise) begin
        foreach (la_q[j]) if (la_q[j] == cyc && $urandom_range(0, 1) == 1) dist_all_done = 1'b1;
        start        = ($urandom_range(0, 3) == 0);
        num_layers   = (L_W + 1)'($urandom_range(0, 5));
        cfg_we       = ($urandom_range(0, 3) == 0);
        cfg_addr     = L_W'($urandom_range(0, 4));
        cfg_p_index  = A_W'($urandom);
        cfg_need_act = 1'($urandom);
      end
      step();
    end
    dist_all_done = 1'b0;
    start  = 1'b0;
    cfg_we = 1'b0;
    check("busy_cleared_at_end", int'(busy), 0);
    if (err_exp) begin
      step();
      check("error_sticky", int'(error), 1);
    end
  endtask

  task automatic abort_case();
    int s;
    s = cyc;
    start         = 1'b1;
    num_layers    = 3;
    timeout_limit = 0;
    push_ev(EV_LAUNCH, s + 2, 0, tbl_p[0], tbl_a[0], 0);
    step();
    while (cyc < s + 4) begin
      start        = 1'b1;
      cfg_we       = 1'b1;
      cfg_addr     = '0;
      cfg_p_index  = A_W'(tbl_p[0] + 1);
      cfg_need_act = 1'(tbl_a[0] + 1);
      step();
    end
    start         = 1'b0;
    cfg_we        = 1'b0;
    abort         = 1'b1;
    dist_all_done = 1'b1;
    step();
    abort         = 1'b0;
    dist_all_done = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_error", int'(error), 0);
    repeat (4) step();
  endtask

  task automatic reset_case();
    int s;
    cfg_write(0, 9, 1);
    cfg_write(1, 3, 1);
    s = cyc;
    start         = 1'b1;
    num_layers    = 2;
    timeout_limit = 0;
    push_ev(EV_LAUNCH, s + 2, 0, 9, 1, 0);
    step();
    start = 1'b0;
    while (cyc < s + 4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_dist_en", int'(dist_en), 0);
    check("rst_done", int'(done), 0);
    check("rst_layer_index", int'(layer_index), 0);
    check("rst_p_index_in", int'(p_index_in), 0);
    check("rst_need_act", int'(need_act), 0);
    check("rst_layers_done", int'(layers_done), 0);
    for (int i = 0; i < 16; i++) begin
      tbl_p[i] = 0;
      tbl_a[i] = 0;
    end
    repeat (2) step();
    dist_all_done = 1'b1;
    step();
    dist_all_done = 1'b0;
    repeat (3) step();
    check("rst_late_all_done_busy", int'(busy), 0);
  endtask

  initial begin
    int d[16];
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_layers = '0; timeout_limit = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_p_index = '0; cfg_need_act = 1'b0;
    dist_all_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tbl_p[i] = 0;
      tbl_a[i] = 0;
    end
    repeat (3) step();
    check("reset_busy", int'(busy), 0);
    check("reset_dist_en", int'(dist_en), 0);
    check("reset_done", int'(done), 0);
    check("reset_error", int'(error), 0);
    check("reset_layer_index", int'(layer_index), 0);
    check("reset_layers_done", int'(layers_done), 0);
    rst = 1'b0;
    step();

    // Two-layer worked example, then the zero-layer run.
    cfg_write(0, 0, 1);
    cfg_write(1, 5, 0);
    d = '{default: 4};
    run_case(2, 0, d, 1'b0, 1'b0);
    step();
    run_case(0, 0, d, 1'b0, 1'b0);
    step();

    // Timeout with no completion, then completion on the expiry cycle.
    d = '{default: 10};
    run_case(2, 3, d, 1'b0, 1'b0);
    repeat (2) step();
    d = '{default: 3};
    run_case(2, 3, d, 1'b0, 1'b0);
    step();

    abort_case();
    d = '{default: 2};
    run_case(1, 0, d, 1'b0, 1'b0);
    step();

    reset_case();
    d = '{default: 1};
    run_case(3, 0, d, 1'b0, 1'b0);
    step();

    repeat (30) begin
      int n, tl, nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        cfg_write($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 1));
      n  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      tl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
      for (int i = 0; i < 16; i++) d[i] = $urandom_range(1, 7);
      run_case(n, tl, d, 1'b1, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(1, 2)) step();
    end

    repeat (4) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameters: A_WIDTH, default 4, p_index width; LAYER_W, default 4, layer index width (16 layers max); TO_WIDTH, default 16, timeout counter width.
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports: clk  in  1  sole clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin a network run; sampled only in IDLE.
REQ-005 abort  in  1  cancel the current run.
REQ-006 num_layers  in  LAYER_W+1  number of layers to execute; sampled with start.
REQ-007 timeout_limit  in  TO_WIDTH  maximum RUN cycles per layer; 0 disables the timeout.
REQ-008 cfg_we  in  1  write strobe for the per-layer config table.
REQ-009 cfg_addr  in  LAYER_W  table entry to write.
REQ-010 cfg_p_index  in  A_WIDTH  start p_index for that layer.
REQ-011 cfg_need_act  in  1  activation flag for that layer.
REQ-012 dist_all_done  in  1  distributor layer-completion flag.
REQ-013 dist_en  out  1  one-cycle launch pulse to the distributor.
REQ-014 layer_index  out  LAYER_W  current layer.
REQ-015 p_index_in  out  A_WIDTH  registered table value for the current layer.
REQ-016 need_act  out  1  registered table value for the current layer.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse on successful completion.
REQ-019 error  out  1  sticky timeout flag.
REQ-020 layers_done  out  LAYER_W+1  count of completed layers in the current run.

Function
REQ-021 States SHALL be IDLE, LOAD, LAUNCH, RUN, NEXT, DONE, ERR.
REQ-022 IDLE with start=1 and num_layers!=0 SHALL go to LOAD; layer_index, layers_done and error are cleared, num_layers is latched.
REQ-023 IDLE with start=1 and num_layers=0 SHALL go to DONE; dist_en is never asserted.
REQ-024 LOAD SHALL register table[layer_index] into p_index_in and need_act, then go to LAUNCH.
REQ-025 LAUNCH SHALL drive dist_en=1 for exactly that cycle, clear the timeout counter, then go to RUN.
REQ-026 RUN SHALL increment a saturating counter each cycle; dist_all_done=1 goes to NEXT.
REQ-027 RUN with timeout_limit!=0, no dist_all_done, and counter reaching timeout_limit SHALL go to ERR.
REQ-028 dist_all_done in the same cycle as timeout expiry SHALL count as success (NEXT).
REQ-029 NEXT SHALL increment layers_done; if layers_done+1 equals the latched num_layers it goes to DONE, else it increments layer_index and goes to LOAD.
REQ-030 DONE SHALL assert done for one cycle, then go to IDLE; layer_index holds its last value.
REQ-031 ERR SHALL set error=1, then go to IDLE; error stays high until the next accepted start or rst.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with no done and no error; abort has priority over dist_all_done and timeout.
REQ-033 Latency SHALL be: start in cycle 0 gives dist_en in cycle 2; dist_all_done in cycle R gives the next dist_en in cycle R+3, or done in cycle R+2 for the last layer.
REQ-034 start while busy, and dist_all_done outside RUN, SHALL be ignored.
REQ-035 cfg_we SHALL write the table only when busy=0 and is ignored while busy.
REQ-036 cfg_we in the same cycle as an accepted start SHALL write the table, and LOAD SHALL see the new value.

Reset
REQ-037 rst SHALL force IDLE and set every output and the counter to 0; table contents reset to 0.
REQ-038 rst mid-run SHALL take effect at the next edge, with no dist_en, done or error pulse afterwards.

Structure
REQ-039 Package nn_ctrl_pkg SHALL hold the state encoding and the default values of A_WIDTH, LAYER_W and TO_WIDTH.
REQ-040 The config table SHALL be sub-module layer_cfg_table: 2^LAYER_W entries of {p_index, need_act}, one synchronous write port and a combinational read port.

Verification
REQ-041 Write table (L0 p=0 act=1; L1 p=5 act=0); start with num_layers=2; all_done 4 cycles after each dist_en -> dist_en at cycles 2 and 9, outputs (0,0,1) then (1,5,0), done at cycle 15, layers_done=2.
REQ-042 num_layers=0 -> done one cycle after start; dist_en never high; busy high for 1 cycle.
REQ-043 timeout_limit=3, no all_done -> ERR after the 3rd RUN cycle; error=1, stays set; the next start clears it.
REQ-044 Timeout expiry and all_done in the same cycle -> NEXT taken; no error.
REQ-045 abort in RUN -> IDLE next cycle, no done; a start during the run and a cfg_we while busy -> both ignored (table unchanged).
REQ-046 rst asserted in RUN -> all outputs 0 next cycle; a later all_done pulse -> no effect.
